reg_bank_reader: RTL
====================

Name: reg_bank_reader

Overview:
- Read-side sequencer for the team's 4-bit operand/result register storage.
- On a start pulse it walks an address range of the register bank, issues one-cycle read strobes, and captures each returned word.
- Presents each word downstream (display/LED driver or serial link) over a valid/ready handshake.
- Sits between the register bank read port and the output/display logic on the Spartan-3E ALU board.

Parameters:
- DATA_W, 4, width of each register word
- ADDR_W, 2, bank address width; bank depth = 2**ADDR_W
- RD_LAT, 1, cycles from rd_en to rd_data valid (1 or 2 supported)

Ports:
- clk  input  1  system clock, all logic on rising edge
- clr_n  input  1  asynchronous active-low reset
- start  input  1  begin readout sweep; sampled only in IDLE
- first_addr  input  ADDR_W  first address of sweep, latched at accepted start
- last_addr  input  ADDR_W  final address of sweep, latched at accepted start
- rd_en  output  1  read strobe to bank, one cycle per word
- rd_addr  output  ADDR_W  read address, valid while rd_en=1
- rd_data  input  DATA_W  bank read data, valid RD_LAT cycles after rd_en
- out_data  output  DATA_W  captured word to downstream
- out_addr  output  ADDR_W  address the out_data came from
- out_valid  output  1  out_data/out_addr valid
- out_ready  input  1  downstream accepts when out_valid & out_ready
- out_last  output  1  high with out_valid on the final word of the sweep
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse after the last word is accepted

Behaviour:
- Reset (clr_n=0, async): state=IDLE; rd_en=0, rd_addr=0, out_data=0, out_addr=0, out_valid=0, out_last=0, busy=0, done=0; latched addresses cleared. Reset mid-sweep aborts immediately; no partial done.
- States: IDLE, READ, WAIT, PRESENT, FINISH.
- IDLE: start=1 latches first_addr/last_addr, cur_addr<=first_addr, go READ. busy rises the cycle after start.
- READ: rd_en=1, rd_addr=cur_addr for exactly one cycle; load wait counter with RD_LAT; go WAIT.
- WAIT: count down; on the cycle rd_data is valid, capture into out_data, out_addr<=cur_addr, out_valid<=1, out_last<=(cur_addr==last_addr); go PRESENT.
- PRESENT: hold out_data/out_addr/out_valid/out_last stable until out_valid&out_ready.
  - On handshake: out_valid<=0, out_last<=0. If the word was last, go FINISH; else cur_addr<=cur_addr+1 (mod 2**ADDR_W, wrap allowed), go READ.
- FINISH: done=1 for one cycle, go IDLE.
- Wrap-around: if last_addr < first_addr, the sweep wraps through max address to 0 and continues to last_addr.
- first_addr==last_addr: exactly one word, out_last=1 on it.
- Throughput: minimum 1+RD_LAT+1 cycles per word with out_ready held high; no bubble-free streaming required.
- start while busy is ignored; first_addr/last_addr changes after acceptance have no effect.
- out_ready while out_valid=0 has no effect.
- rd_data is ignored except on the capture cycle.
- Never more than one outstanding read.

Test Plan:
- Reset, then start with first=0, last=3, bank {0:4'h3, 1:4'hA, 2:4'h5, 3:4'hF}, out_ready=1 -> four rd_en pulses at addr 0,1,2,3; out_data 3,A,5,F; out_last only with F; one done pulse; busy falls with return to IDLE.
- Same sweep with out_ready low for 5 cycles on word 1 -> out_valid/out_data=A held stable 5 cycles; no rd_en issued during the stall; sequence completes unchanged.
- first=3, last=1 -> reads addr 3,0,1 in order; out_last with addr 1; done once.
- first=last=2 -> single rd_en at addr 2; out_valid with out_last=1; done.
- start pulse asserted again mid-sweep, and first/last changed -> ignored, original sweep completes; new start in IDLE afterwards runs normally.
- clr_n low during PRESENT of word 2 -> all outputs 0 immediately, busy=0, no done; after release, IDLE waits for start.
- RD_LAT=2 build -> capture occurs 2 cycles after rd_en; output values match the first scenario.

Source files
------------

// File: rtl/reg_bank_reader.sv
// Read-side sequencer for the operand/result register bank: sweeps an address
// range, issues one read per word and hands each word downstream over valid/ready.
module reg_bank_reader #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 2,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    PRESENT,
    FINISH
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   cur_addr_q;
  logic [ADDR_W-1:0]   last_addr_q;
  logic [1:0]          wait_cnt_q;
  logic                rd_en_q;
  logic [DATA_W-1:0]   out_data_q;
  logic [ADDR_W-1:0]   out_addr_q;
  logic                out_valid_q;
  logic                out_last_q;
  logic                busy_q;
  logic                done_q;

  // NOTE: every register, datapath included, is cleared by the async reset so
  // an aborted sweep leaves no stale word visible downstream.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      last_addr_q <= '0;
      wait_cnt_q  <= '0;
      rd_en_q     <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout; done is a pulse, so it defaults low
      // and only the PRESENT->FINISH transition raises it for one cycle.
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            cur_addr_q  <= first_addr;
            last_addr_q <= last_addr;
            rd_en_q     <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= READ;
          end
        end

        READ: begin
          rd_en_q    <= 1'b0;
          wait_cnt_q <= 2'(RD_LAT);
          state_q    <= WAIT;
        end

        WAIT: begin
          // The bank's data is valid on the last count of the latency window.
          if (wait_cnt_q == 2'd1) begin
            out_data_q  <= rd_data;
            out_addr_q  <= cur_addr_q;
            out_valid_q <= 1'b1;
            out_last_q  <= (cur_addr_q == last_addr_q);
            state_q     <= PRESENT;
          end else begin
            wait_cnt_q <= wait_cnt_q - 2'd1;
          end
        end

        PRESENT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            if (out_last_q) begin
              done_q  <= 1'b1;
              state_q <= FINISH;
            end else begin
              // Address wraps naturally through the top of the bank.
              cur_addr_q <= cur_addr_q + 1'b1;
              rd_en_q    <= 1'b1;
              state_q    <= READ;
            end
          end
        end

        FINISH: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          rd_en_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rd_en     = rd_en_q;
  assign rd_addr   = cur_addr_q;
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
